// File: rtl/debounce_n.sv
// debounce_n: multi-channel switch/button debouncer.
//
// Every channel is brought into the clk domain by a two-flop synchronizer.
// A shared free-running prescaler raises `tick` once every 2**DIV_BITS clk
// cycles. On each tick, a per-channel counter counts consecutive samples
// that differ from the debounced level. The output flips once HOLD
// consecutive differing samples have been seen. A sample that matches the
// current output clears the counter, so any bounce restarts the count.
// `tick` is only a clock enable; the design runs entirely on clk.
//
// Optional feature, compile-time macro DEBOUNCE_EDGE_EN:
//   defined   -> registered one-cycle rise/fall pulses plus a `changed`
//                summary strobe.
//   undefined -> rise/fall/changed are tied to 0 and the edge registers
//                are omitted.
module debounce_n #(
  parameter int               WIDTH     = 1,
  parameter int               DIV_BITS  = 15,
  parameter int               CNT_BITS  = 4,
  parameter int               HOLD      = 10,   // legal range 1 .. 2**CNT_BITS-1
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             changed,
  output logic             tick
);

  localparam logic [CNT_BITS-1:0] HOLD_LAST = CNT_BITS'(HOLD - 1);

  logic [DIV_BITS-1:0] div_q;
  logic [WIDTH-1:0]    s1_q, s2_q;
  logic [WIDTH-1:0]    out_q, out_d;
  logic [CNT_BITS-1:0] cnt_q [WIDTH];
  logic [CNT_BITS-1:0] cnt_d [WIDTH];

  // The strobe is decoded from the counter, so it is high in exactly one
  // cycle of every prescaler period. It is 0 after reset because the
  // counter is then 0.
  assign tick = &div_q;

  // Free-running prescaler. It wraps naturally from all-ones to zero.
  // NOTE: every flop assignment here uses <= so that all registers sample
  // their inputs from the same edge; a blocking = would let later lines see
  // values already updated in this cycle.
  always_ff @(posedge clk) begin
    if (reset) div_q <= '0;
    else       div_q <= div_q + DIV_BITS'(1);
  end

  // Two-flop synchronizer that moves the raw inputs into the clk domain.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_q <= RESET_VAL;
      s2_q <= RESET_VAL;
    end else begin
      s1_q <= in;
      s2_q <= s1_q;
    end
  end

  // Per-channel stability decision. It only advances on ticks.
  // NOTE: the defaults at the top of this block give every output a value
  // on every path; without them an untaken branch would infer a latch.
  always_comb begin
    out_d = out_q;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (tick) begin
        if (s2_q[i] == out_q[i]) begin
          cnt_d[i] = '0;
        end else if (cnt_q[i] == HOLD_LAST) begin
          out_d[i] = s2_q[i];
          cnt_d[i] = '0;
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_BITS'(1);
        end
      end
    end
  end

  // Debounced level and stability counters. Reset drops any partial count.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= RESET_VAL;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      out_q <= out_d;
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign out = out_q;

`ifdef DEBOUNCE_EDGE_EN
  logic [WIDTH-1:0] rise_q, fall_q;

  // Edge pulses are registered together with out, so each pulse lines up
  // with the first cycle that shows the new level. Reset never produces a
  // pulse, because it forces the pulse registers to 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      rise_q <= out_d & ~out_q;
      fall_q <= ~out_d & out_q;
    end
  end

  assign rise    = rise_q;
  assign fall    = fall_q;
  assign changed = |(rise_q | fall_q);
`else
  assign rise    = '0;
  assign fall    = '0;
  assign changed = 1'b0;
`endif

endmodule

// File: tb/tb_debounce_n.sv
// tb_debounce_n: self-checking bench for debounce_n.
// Configuration: WIDTH=4, DIV_BITS=2, HOLD=3, RESET_VAL=0. The expected
// edge outputs follow DEBOUNCE_EDGE_EN.
// The reference model keeps a sliding window of the last HOLD tick samples
// for each channel. A channel flips when every sample in that window
// differs from its current level.
module tb_debounce_n;

  localparam int WIDTH    = 4;
  localparam int DIV_BITS = 2;
  localparam int CNT_BITS = 4;
  localparam int HOLD     = 3;
  localparam int PERIOD   = 1 << DIV_BITS;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] din;
  logic [WIDTH-1:0] dout, rise, fall;
  logic             changed, tick;

  int n_checks = 0;
  int n_errors = 0;

  debounce_n #(
    .WIDTH    (WIDTH),
    .DIV_BITS (DIV_BITS),
    .CNT_BITS (CNT_BITS),
    .HOLD     (HOLD),
    .RESET_VAL(4'h0)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .in     (din),
    .out    (dout),
    .rise   (rise),
    .fall   (fall),
    .changed(changed),
    .tick   (tick)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int               k_m;          // clk edges since the last reset edge
  logic [WIDTH-1:0] s1_m, s2_m, out_m, rise_m, fall_m;
  logic [WIDTH-1:0] win_q [$];    // the last HOLD tick samples
  bit               model_valid = 0;

  always @(posedge clk) begin
    logic [WIDTH-1:0] prev;
    bit all_diff;
    if (reset) begin
      k_m = 0; s1_m = '0; s2_m = '0; out_m = '0; rise_m = '0; fall_m = '0;
      win_q.delete();
      model_valid = 1;
    end else if (model_valid) begin
      prev = out_m;
      if (k_m % PERIOD == PERIOD - 1) begin
        win_q.push_back(s2_m);
        if (win_q.size() > HOLD) void'(win_q.pop_front());
        if (win_q.size() == HOLD) begin
          for (int ch = 0; ch < WIDTH; ch++) begin
            all_diff = 1;
            foreach (win_q[j]) if (win_q[j][ch] == prev[ch]) all_diff = 0;
            if (all_diff) out_m[ch] = ~prev[ch];
          end
        end
      end
      rise_m = out_m & ~prev;
      fall_m = ~out_m & prev;
      k_m++;
      s2_m = s1_m;
      s1_m = din;
    end
  end

  // Compare the DUT with the model on every falling edge once reset has been seen.
  always @(negedge clk) begin
    if (model_valid) begin
      check("cmp_out",  dout, out_m);
      check("cmp_tick", tick, (k_m % PERIOD == PERIOD - 1));
`ifdef DEBOUNCE_EDGE_EN
      check("cmp_rise",    rise,    rise_m);
      check("cmp_fall",    fall,    fall_m);
      check("cmp_changed", changed, |(rise_m | fall_m));
`else
      check("cmp_rise",    rise,    0);
      check("cmp_fall",    fall,    0);
      check("cmp_changed", changed, 0);
`endif
    end
  end

  // ---------------- directed stimulus ----------------
  logic [WIDTH-1:0] exp_edge;
  int n, pulses, hi_cnt, ticks, seen;

  initial begin
`ifdef DEBOUNCE_EDGE_EN
    exp_edge = 4'hF;
`else
    exp_edge = 4'h0;
`endif
    din   = '0;
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_out",     dout,    0);
    check("reset_rise",    rise,    0);
    check("reset_fall",    fall,    0);
    check("reset_changed", changed, 0);
    check("reset_tick",    tick,    0);
    reset = 1'b0;

    // Quiet inputs: no pulses; tick on every 4th cycle, first at edge 3.
    pulses = 0; ticks = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 2) check("tick_not_yet", tick, 0);
      if (c == 3) check("tick_first",   tick, 1);
      ticks  += int'(tick);
      pulses += int'(|rise) + int'(|fall) + int'(changed);
    end
    check("quiet_out",    dout,   0);
    check("quiet_pulses", pulses, 0);
    check("quiet_ticks",  ticks,  10);

    // Single channel rising: out[0] must rise 9..15 clk after the change.
    din[0] = 1'b1;
    n = 0; seen = 0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      if (dout[0]) begin
        seen = 1; n = c;
        check("ch0_rise_pulse", rise[0], exp_edge[0]);
        check("ch0_changed",    changed, exp_edge[0]);
        check("ch0_rise_other", rise[3:1], 0);
      end
    end
    check("ch0_rose",          seen, 1);
    check("ch0_latency_in_win", (n >= 9 && n <= 15), 1);
    check("ch0_latency_exact", n, 12);
    @(negedge clk);
    check("ch0_rise_one_cycle", rise[0], 0);
    din[0] = 1'b0;
    repeat (20) @(negedge clk);
    check("ch0_back_low", dout[0], 0);

    // Bouncing channel 1: 5 high / 6 low never survives 3 ticks.
    pulses = 0; hi_cnt = 0;
    for (int c = 0; c < 100; c++) begin
      din[1] = (c % 11) < 5;
      @(negedge clk);
      hi_cnt += int'(dout[1]);
      pulses += int'(rise[1]) + int'(fall[1]);
    end
    check("bounce_out_high_cycles", hi_cnt, 0);
    check("bounce_pulses",          pulses, 0);
    din = '0;
    repeat (12) @(negedge clk);

    // All channels together, up then down.
    din = 4'hF;
    seen = 0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      if (dout != 0) begin
        seen = 1;
        check("all_out_together", dout, 4'hF);
        check("all_rise",         rise, exp_edge);
        check("all_fall_quiet",   fall, 0);
      end
    end
    check("all_rose", seen, 1);
    @(negedge clk);
    check("all_rise_one_cycle", rise, 0);
    din = 4'h0;
    seen = 0;
    for (int c = 1; c <= 40 && !seen; c++) begin
      @(negedge clk);
      if (dout != 4'hF) begin
        seen = 1;
        check("all_out_low", dout, 4'h0);
        check("all_fall",    fall, exp_edge);
        check("all_rise_quiet", rise, 0);
      end
    end
    check("all_fell", seen, 1);
    repeat (4) @(negedge clk);

    // Channel 2 with a reset pulse after 2 ticks: partial count discarded.
    din[2] = 1'b1;
    ticks = 0;
    for (int c = 1; c <= 20 && ticks < 2; c++) begin
      @(negedge clk);
      ticks += int'(tick);
    end
    check("rst_mid_two_ticks", ticks, 2);
    check("rst_mid_out_before", dout[2], 0);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_out",    dout, 0);
    check("rst_mid_rise",   rise, 0);
    check("rst_mid_fall",   fall, 0);
    check("rst_mid_change", changed, 0);
    reset = 1'b0;
    repeat (11) @(negedge clk);
    check("rst_mid_out_edge11", dout[2], 0);
    @(negedge clk);
    check("rst_mid_out_edge12", dout[2], 1);
    check("rst_mid_rise12",     rise[2], exp_edge[2]);
    repeat (4) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
